// File: rtl/lsu_pkg.sv
// lsu_pkg: op codes, FSM states and op-decoding helpers for the load/store unit
package lsu_pkg;
    localparam logic [5:0] OP_LB = 6'd1, OP_LH = 6'd2, OP_LW = 6'd3, OP_LBU = 6'd4, OP_LHU = 6'd5,
        OP_SB = 6'd6, OP_SH = 6'd7, OP_SW = 6'd8, OP_LWU = 6'd9, OP_LD = 6'd10, OP_SD = 6'd11;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
    function automatic logic op_legal(input logic [5:0] op, input logic wide);
        return (op >= OP_LB && op <= OP_SW) || (wide && op >= OP_LWU && op <= OP_SD);
    endfunction
    function automatic logic op_store(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW || op == OP_SD;
    endfunction
    function automatic logic op_signed(input logic [5:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW;
    endfunction
    function automatic logic [1:0] op_size(input logic [5:0] op);
        return (op == OP_LB || op == OP_LBU || op == OP_SB) ? 2'd0 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2'd1 :
               (op == OP_LD || op == OP_SD) ? 2'd3 : 2'd2;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane shift/strobes, load extract/extend and misalignment flag
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFF = $clog2(DATA_W / 8),
    localparam int NB = DATA_W / 8
) (
    input  logic [5:0]        st_op,
    input  logic [OFF-1:0]    st_lane,
    input  logic [DATA_W-1:0] st_data,
    input  logic [5:0]        ld_op,
    input  logic [OFF-1:0]    ld_lane,
    input  logic [DATA_W-1:0] ld_q,
    output logic              misalign,
    output logic [NB-1:0]     we,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] ld_data
);
    logic [1:0] st_sz, ld_sz;
    logic [NB-1:0] bm;
    logic [DATA_W-1:0] dm, sh;
    logic sg;
    always_comb begin
        st_sz = op_size(st_op);
        ld_sz = op_size(ld_op);
        sg = op_signed(ld_op);
        bm = NB'((16'd1 << (5'd1 << st_sz)) - 16'd1);
        dm = '0;
        for (int i = 0; i < NB; i++) dm[8*i +: 8] = {8{bm[i]}};
        misalign = |(st_lane & OFF'((4'd1 << st_sz) - 4'd1));
        we = op_store(st_op) ? bm << st_lane : '0;
        d = (st_data & dm) << {st_lane, 3'b000};
        sh = ld_q >> {ld_lane, 3'b000};
        ld_data = ld_sz == 2'd0 ? (sg ? DATA_W'($signed(sh[7:0])) : DATA_W'(sh[7:0])) :
                  ld_sz == 2'd1 ? (sg ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0])) :
                  ld_sz == 2'd2 ? (sg ? DATA_W'($signed(sh[31:0])) : DATA_W'(sh[31:0])) : sh;
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit with req/gnt/rvalid handshake, misalign and timeout traps
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TIMEOUT_CYC = 255,
    localparam int OFF = $clog2(DATA_W / 8),
    localparam int NB = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  jump_branch_enable,
    input  logic                  req_valid,
    input  logic [5:0]            operation_con,
    input  logic [DATA_W-1:0]     src1_value,
    input  logic [DATA_W-1:0]     src2_value,
    input  logic [DATA_W-1:0]     imm,
    input  logic [4:0]            rd,
    output logic                  stall,
    output logic                  write_req,
    output logic [4:0]            write_addr,
    output logic [DATA_W-1:0]     write_data,
    output logic                  misalign_exc,
    output logic                  bus_err,
    output logic [ADDR_W-1:0]     exc_addr,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_W-OFF-1:0] mem_addr,
    output logic [NB-1:0]         mem_we,
    output logic [DATA_W-1:0]     mem_d,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_q
);
    localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr, addr_q;
    logic [5:0] op_q;
    logic [4:0] rd_q;
    logic [NB-1:0] we_nx, we_q;
    logic [DATA_W-1:0] d_nx, d_q, ld_data;
    logic [CW-1:0] cnt;
    logic misalign, accept, timeout, done;
    assign addr = ADDR_W'(src1_value + imm);
    lsu_align #(.DATA_W(DATA_W)) u_align (
        .st_op(operation_con),
        .st_lane(addr[OFF-1:0]),
        .st_data(src2_value),
        .ld_op(op_q),
        .ld_lane(addr_q[OFF-1:0]),
        .ld_q(mem_q),
        .misalign(misalign),
        .we(we_nx),
        .d(d_nx),
        .ld_data(ld_data)
    );
    always_comb begin
        accept = state == IDLE && req_valid && op_legal(operation_con, DATA_W == 64) && !jump_branch_enable;
        done = state == RESP && mem_rvalid;
        timeout = TIMEOUT_CYC != 0 && state != IDLE && cnt == CW'(TIMEOUT_CYC);
        state_nx = accept && !misalign ? REQ :
                   done || timeout ? IDLE :
                   state == REQ && mem_gnt ? RESP : state;
        stall = (accept && !misalign) || (state != IDLE && !done);
        mem_req = state == REQ;
        mem_we = mem_req ? we_q : '0;
        mem_addr = addr_q[ADDR_W-1:OFF];
        mem_d = d_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            op_q <= '0;
            rd_q <= '0;
            we_q <= '0;
            d_q <= '0;
            write_req <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            misalign_exc <= 1'b0;
            bus_err <= 1'b0;
            exc_addr <= '0;
        end else begin
            state <= state_nx;
            cnt <= state == IDLE ? '0 : cnt + CW'(1);
            misalign_exc <= accept && misalign;
            bus_err <= timeout && !done;
            write_req <= done && !op_store(op_q) && rd_q != 5'd0;
            if (accept && !misalign) begin
                addr_q <= addr;
                op_q <= operation_con;
                rd_q <= rd;
                we_q <= we_nx;
                d_q <= d_nx;
            end
            if (accept && misalign) exc_addr <= addr;
            else if (timeout && !done) exc_addr <= addr_q;
            if (done && !op_store(op_q) && rd_q != 5'd0) begin
                write_addr <= rd_q;
                write_data <= ld_data;
            end
        end
    end
endmodule
